rca_sub_seq: RTL
================

RCA_SUB_SEQ -- requirements
Module: rca_sub_seq

Interface
REQ-001 SHALL have parameter WIDTH, default 32: operand and result width in bits.
REQ-002 SHALL have parameter CHUNK, default 4: bits processed per cycle; WIDTH SHALL be divisible by CHUNK (elaboration error otherwise).
REQ-003 SHALL have port clk, input, 1: sole clock; all state changes on its rising edge.
REQ-004 SHALL have port rst, input, 1: asynchronous, active-high reset.
REQ-005 SHALL have port in_valid, input, 1: operand set a, b, bin is valid.
REQ-006 SHALL have port in_ready, output, 1: block accepts an operand set.
REQ-007 SHALL have ports a and b, input, WIDTH each: minuend and subtrahend, unsigned.
REQ-008 SHALL have port bin, input, 1: borrow-in.
REQ-009 SHALL have port out_valid, output, 1: result valid.
REQ-010 SHALL have port out_ready, input, 1: consumer accepts result.
REQ-011 SHALL have port d, output, WIDTH: difference a - b - bin, modulo 2^WIDTH.
REQ-012 SHALL have port bout, output, 1: borrow-out; 1 iff a < b + bin.
REQ-013 SHALL have port ovf, output, 1: signed overflow; present only under REQ-027.

Function
REQ-014 SHALL implement FSM states IDLE, RUN, DONE.
- IDLE -> RUN on accept (in_valid & in_ready).
- RUN -> DONE after NSTEP = WIDTH/CHUNK steps.
- DONE -> IDLE on out_valid & out_ready.
REQ-015 SHALL drive in_ready = 1 only in IDLE, and out_valid = 1 only in DONE.
REQ-016 SHALL capture a, b and bin on the accept edge; input changes after that edge SHALL NOT affect the result.
REQ-017 SHALL compute one CHUNK-bit ripple-borrow slice per RUN cycle, LSB chunk first, passing the borrow register between steps; the step counter SHALL run 0..NSTEP-1.
REQ-018 SHALL assert out_valid after edge T+NSTEP, where T is the accept edge (8 cycles for the defaults).
REQ-019 SHALL hold d, bout and ovf stable while out_valid = 1 and out_ready = 0, for any number of cycles.
REQ-020 SHALL NOT accept new input in the cycle the result is consumed; the next accept is earliest one edge after DONE -> IDLE.
REQ-021 SHALL keep d, bout and ovf at their last values in IDLE and RUN; they are don't-care to the consumer while out_valid = 0.
REQ-022 SHALL handle wrap-around: 0 - 1 yields all-ones with bout = 1.

Reset
REQ-023 SHALL, on rst = 1, immediately force state IDLE, step counter 0, borrow register 0, d = 0, bout = 0, ovf = 0, out_valid = 0 and in_ready = 1 (asserted from the first edge after release).
REQ-024 SHALL abandon any in-flight operation on reset during RUN or DONE and emit no partial result.
REQ-025 SHALL ignore in_valid while rst = 1.

Configuration
REQ-026 SHALL use macro RCA_SUB_OVF_EN.
REQ-027 SHALL, when RCA_SUB_OVF_EN is defined, include port ovf = (a[MSB] != b[MSB]) & (d[MSB] != a[MSB]), registered with d.
REQ-028 SHALL, when RCA_SUB_OVF_EN is undefined, contain no ovf port or ovf logic; all other behaviour is identical.

Structure
REQ-029 SHALL take the default WIDTH and CHUNK, the derived NSTEP, the step-counter width $clog2(NSTEP) and the FSM state enum from shared package rca_sub_pkg.
REQ-030 SHALL instantiate one combinational sub-module, sub_slice: a CHUNK-bit ripple-borrow subtractor with inputs x, y, bi and outputs diff, bo, built from per-bit full-subtractor equations.

Verification
REQ-031 Scenario: a = 5, b = 3, bin = 0 -> d = 2, bout = 0, out_valid exactly 8 cycles after accept.
REQ-032 Scenario: a = 0, b = 1, bin = 0 -> d = 0xFFFFFFFF, bout = 1; with a = b = 0x1234, bin = 1 -> d = 0xFFFFFFFF, bout = 1.
REQ-033 Scenario: result ready, out_ready held low 5 cycles -> d, bout and out_valid stable and in_ready = 0 throughout; consumed on the 6th cycle; in_ready = 1 on the next cycle.
REQ-034 Scenario: rst pulsed at RUN step 3 -> out_valid never asserts for that operation, in_ready = 1 after release, next operation 7 - 2 = 5 correct.
REQ-035 Scenario (RCA_SUB_OVF_EN): a = 0x80000000, b = 1 -> d = 0x7FFFFFFF, ovf = 1, bout = 0; a = 3, b = 1 -> ovf = 0.
REQ-036 Scenario: 10,000 random a/b/bin operations with random out_ready stalls -> every result matches a reference model of (a - b - bin) mod 2^32 and its borrow.

Source files
------------

// File: rtl/rca_sub_pkg.sv
// Shared defaults, derived step/counter sizes and FSM encoding for the
// sequential ripple-borrow subtractor.
package rca_sub_pkg;

  localparam int WIDTH_DEF = 32;
  localparam int CHUNK_DEF = 4;

  function automatic int nstep_of(input int width, input int chunk);
    return width / chunk;
  endfunction

  // A single-step configuration still needs a one-bit counter to exist.
  function automatic int cnt_width(input int nstep);
    return (nstep > 1) ? $clog2(nstep) : 1;
  endfunction

  localparam int NSTEP_DEF = nstep_of(WIDTH_DEF, CHUNK_DEF);
  localparam int CNT_W_DEF = cnt_width(NSTEP_DEF);

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    RUN  = 2'd1,
    DONE = 2'd2
  } state_t;

endpackage

// File: rtl/rca_sub_seq_sub_slice.sv
// CHUNK-bit combinational ripple-borrow subtractor built from per-bit
// full-subtractor equations: diff = x - y - bi.
module sub_slice #(
  parameter int CHUNK = 4
) (
  input  logic [CHUNK-1:0] x,
  input  logic [CHUNK-1:0] y,
  input  logic             bi,
  output logic [CHUNK-1:0] diff,
  output logic             bo
);

  logic borrow;

  // NOTE: blocking assignments here are intentional -- each bit must see the
  // borrow produced by the bit below it within the same evaluation.
  always_comb begin
    borrow = bi;
    diff   = '0;
    for (int i = 0; i < CHUNK; i++) begin
      diff[i] = x[i] ^ y[i] ^ borrow;
      borrow  = (~x[i] & y[i]) | (~(x[i] ^ y[i]) & borrow);
    end
    bo = borrow;
  end

endmodule

// File: rtl/rca_sub_seq.sv
// Sequential subtractor: d = a - b - bin (mod 2^WIDTH), one CHUNK-bit slice per
// cycle, LSB first. Optional signed-overflow output enabled by RCA_SUB_OVF_EN.
module rca_sub_seq
  import rca_sub_pkg::*;
#(
  parameter int WIDTH = WIDTH_DEF,
  parameter int CHUNK = CHUNK_DEF
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  input  logic             bin,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [WIDTH-1:0] d,
  output logic             bout
`ifdef RCA_SUB_OVF_EN
  ,
  output logic             ovf
`endif
);

  localparam int NSTEP = nstep_of(WIDTH, CHUNK);
  localparam int CNT_W = cnt_width(NSTEP);

  if ((CHUNK < 1) || (WIDTH % CHUNK != 0)) begin : g_bad_chunk
    $error("rca_sub_seq: WIDTH must be a positive multiple of CHUNK");
  end

  state_t             state_q, state_d;
  logic [CNT_W-1:0]   step_q;
  logic               br_q;
  logic [WIDTH-1:0]   a_sh, b_sh, acc_q, acc_next;
  logic [CHUNK-1:0]   s_diff;
  logic               s_bo;
  logic               accept, consume, last_step;

  assign accept    = in_valid & in_ready;
  assign consume   = out_valid & out_ready;
  assign last_step = (state_q == RUN) && (step_q == CNT_W'(NSTEP - 1));

  // ---------------- FSM: state register ----------------
  // NOTE: sequential state uses non-blocking assignments so every register
  // samples pre-edge values, independent of process ordering.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) state_q <= IDLE;
    else     state_q <= state_d;
  end

  // ---------------- FSM: next state ----------------
  // NOTE: state_d gets a default first so no path leaves it unassigned,
  // which would otherwise infer a latch.
  always_comb begin
    state_d = state_q;
    unique case (state_q)
      IDLE:    if (accept)    state_d = RUN;
      RUN:     if (last_step) state_d = DONE;
      DONE:    if (consume)   state_d = IDLE;
      default:                state_d = IDLE;
    endcase
  end

  // ---------------- FSM: outputs ----------------
  // in_ready is masked by rst so in_valid is ignored while reset is held.
  always_comb begin
    in_ready  = (state_q == IDLE) && !rst;
    out_valid = (state_q == DONE);
  end

  // ---------------- datapath ----------------
  sub_slice #(.CHUNK(CHUNK)) u_slice (
    .x    (a_sh[CHUNK-1:0]),
    .y    (b_sh[CHUNK-1:0]),
    .bi   (br_q),
    .diff (s_diff),
    .bo   (s_bo)
  );

  // Each new slice enters at the top, so after NSTEP steps the LSB chunk has
  // reached bit 0 and acc holds the full difference.
  assign acc_next = (acc_q >> CHUNK) | (WIDTH'(s_diff) << (WIDTH - CHUNK));

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      a_sh   <= '0;
      b_sh   <= '0;
      acc_q  <= '0;
      br_q   <= 1'b0;
      step_q <= '0;
    end else if (accept) begin
      a_sh   <= a;
      b_sh   <= b;
      acc_q  <= '0;
      br_q   <= bin;
      step_q <= '0;
    end else if (state_q == RUN) begin
      a_sh   <= a_sh >> CHUNK;
      b_sh   <= b_sh >> CHUNK;
      acc_q  <= acc_next;
      br_q   <= s_bo;
      step_q <= last_step ? '0 : step_q + CNT_W'(1);
    end
  end

  // Result registers only load on the last step, so they hold through IDLE,
  // RUN and any DONE stall.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      d    <= '0;
      bout <= 1'b0;
    end else if (last_step) begin
      d    <= acc_next;
      bout <= s_bo;
    end
  end

`ifdef RCA_SUB_OVF_EN
  logic a_msb_q, b_msb_q;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      a_msb_q <= 1'b0;
      b_msb_q <= 1'b0;
      ovf     <= 1'b0;
    end else begin
      if (accept) begin
        a_msb_q <= a[WIDTH-1];
        b_msb_q <= b[WIDTH-1];
      end
      if (last_step) begin
        ovf <= (a_msb_q != b_msb_q) & (acc_next[WIDTH-1] != a_msb_q);
      end
    end
  end
`endif

endmodule
